// File: rtl/rv32i_fetch_if.sv
// rv32i fetch stage bus bundle: instruction memory port plus
// the decode-side handshake (stall/redirect in, instruction strobe out).
interface rv32i_fetch_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_req_o;
  logic            mem_ack_i;
  logic [31:0]     mem_data_i;
  logic            stall_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_addr_i;
  logic [31:0]     instruction_o;
  logic [XLEN-1:0] pc_o;
  logic            data_ready_o;

  modport master (
    output mem_addr_o,
    output mem_req_o,
    input  mem_ack_i,
    input  mem_data_i,
    input  stall_i,
    input  redirect_i,
    input  redirect_addr_i,
    output instruction_o,
    output pc_o,
    output data_ready_o
  );

  modport slave (
    input  mem_addr_o,
    input  mem_req_o,
    output mem_ack_i,
    output mem_data_i,
    output stall_i,
    output redirect_i,
    output redirect_addr_i,
    input  instruction_o,
    input  pc_o,
    input  data_ready_o
  );
endinterface

// File: rtl/rv32i_fetch.sv
// rv32i instruction fetch stage: one outstanding memory read,
// small instruction FIFO, one-cycle strobes to decode, redirect flush.
module rv32i_fetch #(
  parameter int              XLEN         = 32,
  parameter int              FIFO_DEPTH   = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic clk_i,
  input  logic rst_i,
  rv32i_fetch_if.master bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  state_t state;
  state_t state_next;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] stale_addr;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_pc;

  logic [31:0]     fifo_instr [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;

  logic            ack;
  logic            push;
  logic            pop;
  logic            has_room;

  logic [31:0]     instr;
  logic [XLEN-1:0] next_pc;
  logic            ready;

  assign pc_plus4    = fetch_pc + XLEN'(4);
  assign redirect_pc = bus.redirect_addr_i & ~XLEN'(3);

  // Acks are only honoured while a request is actually on the bus.
  assign ack  = bus.mem_ack_i & (state != IDLE);
  assign push = ack & (state == REQ) & ~bus.redirect_i;
  assign pop  = (count != '0) & ~bus.stall_i
              & ~bus.redirect_i;

  always_comb begin
    count_next = count;
    if (bus.redirect_i)
      count_next = '0;
    else
      count_next = count + CW'(push) - CW'(pop);
  end

  assign has_room = count_next < CW'(FIFO_DEPTH);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (!bus.redirect_i && has_room)
          state_next = REQ;
      end
      REQ: begin
        if (bus.redirect_i)
          state_next = ack ? IDLE : DISCARD;
        else if (ack)
          state_next = has_room ? REQ : IDLE;
      end
      DISCARD: begin
        // Stale read must complete before the bus can be reused.
        if (ack)
          state_next = (has_room && !bus.redirect_i)
                     ? REQ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc   <= RESET_VECTOR;
      stale_addr <= RESET_VECTOR;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      instr      <= 32'h0000_0013;
      next_pc    <= '0;
      ready      <= 1'b0;
    end else begin
      count <= count_next;
      ready <= pop;
      if (bus.redirect_i) begin
        fetch_pc <= redirect_pc;
        wptr     <= '0;
        rptr     <= '0;
        if (state == REQ && !ack)
          stale_addr <= fetch_pc;
      end else begin
        if (push) begin
          fetch_pc <= pc_plus4;
          wptr     <= wptr + AW'(1);
        end
        if (pop)
          rptr <= rptr + AW'(1);
      end
      if (pop) begin
        instr   <= fifo_instr[rptr];
        next_pc <= fifo_pc[rptr];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr[wptr] <= bus.mem_data_i;
      fifo_pc[wptr]    <= pc_plus4;
    end
  end

  assign bus.mem_req_o     = (state != IDLE);
  assign bus.mem_addr_o    = (state == DISCARD)
                           ? stale_addr : fetch_pc;
  assign bus.instruction_o = instr;
  assign bus.pc_o          = next_pc;
  assign bus.data_ready_o  = ready;
endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed bench for rv32i_fetch: bus responder, strobe scoreboard,
// stall fill, DISCARD redirect, ack-cycle redirect and PC wrap.
module tb_rv32i_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_fetch_if #(.XLEN(32)) bus ();
  rv32i_fetch_if #(.XLEN(32)) wbus ();

  rv32i_fetch #(
    .XLEN(32), .FIFO_DEPTH(2), .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  rv32i_fetch #(
    .XLEN(32), .FIFO_DEPTH(2), .RESET_VECTOR(32'hFFFF_FFFC)
  ) dut_wrap (
    .clk_i(clk), .rst_i(rst), .bus(wbus)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          waits       = 0;
  int          drop_next   = 0;
  int          ack_total   = 0;
  int          wcnt        = 0;
  logic [31:0] ack_addr    = '0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (bus.mem_ack_i !== 1'b1 && n < 20);
    check(tag, 32'(bus.mem_ack_i), 32'd1);
  endtask

  // Memory responder: data = address, programmable wait states.
  initial begin
    exp_t e;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_req_o === 1'b1) begin
        if (wcnt >= waits) begin
          bus.mem_ack_i  = 1'b1;
          bus.mem_data_i = bus.mem_addr_o;
          ack_addr       = bus.mem_addr_o;
          ack_total++;
          wcnt = 0;
          if (drop_next > 0) begin
            drop_next--;
          end else begin
            e.instr = bus.mem_addr_o;
            e.pc    = bus.mem_addr_o + 32'd4;
            sb.push_back(e);
          end
        end else begin
          bus.mem_ack_i = 1'b0;
          wcnt++;
        end
      end else begin
        bus.mem_ack_i = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Zero-wait responder for the wrap instance.
  initial begin
    wbus.mem_ack_i       = 1'b0;
    wbus.mem_data_i      = '0;
    wbus.stall_i         = 1'b0;
    wbus.redirect_i      = 1'b0;
    wbus.redirect_addr_i = '0;
    forever begin
      @(negedge clk);
      wbus.mem_ack_i  = wbus.mem_req_o;
      wbus.mem_data_i = wbus.mem_addr_o;
    end
  end

  // Strobe monitor: every strobe must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.data_ready_o === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe",
                32'(bus.data_ready_o), 32'd0);
        end else begin
          e = sb.pop_front();
          check("strobe_instr", bus.instruction_o, e.instr);
          check("strobe_pc", bus.pc_o, e.pc);
        end
      end
    end
  end

  initial begin
    logic [31:0] a_stale;
    bit          found;

    bus.stall_i         = 1'b1;
    bus.redirect_i      = 1'b0;
    bus.redirect_addr_i = '0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_req", 32'(bus.mem_req_o), 32'd0);
      check("rst_ready", 32'(bus.data_ready_o), 32'd0);
      check("rst_instr", bus.instruction_o, 32'h13);
      check("rst_pc", bus.pc_o, 32'd0);
      check("rst_addr", bus.mem_addr_o, 32'd0);
    end
    check("wrap_rst_addr", wbus.mem_addr_o, 32'hFFFF_FFFC);
    rst = 1'b0;

    // Stall fill from reset: two acks then the bus goes quiet.
    @(posedge clk); #1;
    check("c1_req", 32'(bus.mem_req_o), 32'd1);
    check("c1_addr", bus.mem_addr_o, 32'd0);
    check("wrap_c1_req", 32'(wbus.mem_req_o), 32'd1);
    check("wrap_c1_addr", wbus.mem_addr_o, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("c2_req", 32'(bus.mem_req_o), 32'd1);
    check("c2_addr", bus.mem_addr_o, 32'd4);
    check("wrap_c2_addr", wbus.mem_addr_o, 32'd0);
    @(posedge clk); #1;
    check("c3_req", 32'(bus.mem_req_o), 32'd0);
    check("wrap_c3_ready", 32'(wbus.data_ready_o), 32'd1);
    check("wrap_c3_pc", wbus.pc_o, 32'd0);
    check("wrap_c3_instr", wbus.instruction_o, 32'hFFFF_FFFC);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      check("fill_ready", 32'(bus.data_ready_o), 32'd0);
      check("fill_req", 32'(bus.mem_req_o), 32'd0);
    end
    check("fill_acks", 32'(ack_total), 32'd2);
    bus.stall_i = 1'b0;

    // Release: fetching resumes at 0x8, then a solid strobe stream.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (bus.mem_req_o === 1'b1) found = 1'b1;
    end
    check("resume_req_seen", 32'(found), 32'd1);
    check("resume_addr", bus.mem_addr_o, 32'd8);
    @(posedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      check("stream_ready", 32'(bus.data_ready_o), 32'd1);
      @(posedge clk); #1;
    end

    // Redirect one cycle into a 3-wait-state request.
    waits = 3;
    wait_ack("pre_discard_ack");
    @(posedge clk); #1;
    a_stale = ack_addr + 32'd4;
    check("discard_req", 32'(bus.mem_req_o), 32'd1);
    check("discard_req_addr", bus.mem_addr_o, a_stale);
    @(posedge clk); #1;
    bus.redirect_i      = 1'b1;
    bus.redirect_addr_i = 32'h200;
    drop_next           = 1;
    @(posedge clk); #1;
    bus.redirect_i = 1'b0;
    sb.delete();
    check("redir_ready", 32'(bus.data_ready_o), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk); #1;
      check("stale_req", 32'(bus.mem_req_o), 32'd1);
      check("stale_addr", bus.mem_addr_o, a_stale);
      if (bus.mem_ack_i === 1'b1) found = 1'b1;
    end
    check("stale_ack_seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    check("post_discard_req", 32'(bus.mem_req_o), 32'd1);
    check("post_discard_addr", bus.mem_addr_o, 32'h200);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (bus.data_ready_o === 1'b1) found = 1'b1;
    end
    check("redir_strobe_seen", 32'(found), 32'd1);
    check("redir_first_pc", bus.pc_o, 32'h204);
    check("redir_first_instr", bus.instruction_o, 32'h200);

    // Redirect on the ack cycle with one word buffered.
    bus.stall_i = 1'b1;
    wait_ack("buffered_ack");
    @(posedge clk); #1;
    wait_ack("redirect_ack");
    bus.redirect_i      = 1'b1;
    bus.redirect_addr_i = 32'h103;
    @(posedge clk); #1;
    bus.redirect_i = 1'b0;
    sb.delete();
    check("ackredir_ready", 32'(bus.data_ready_o), 32'd0);
    check("ackredir_req", 32'(bus.mem_req_o), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (bus.mem_req_o === 1'b1) found = 1'b1;
    end
    check("ackredir_req_seen", 32'(found), 32'd1);
    check("ackredir_addr", bus.mem_addr_o, 32'h100);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("flush_ready", 32'(bus.data_ready_o), 32'd0);
    end
    bus.stall_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (bus.data_ready_o === 1'b1) found = 1'b1;
    end
    check("flush_strobe_seen", 32'(found), 32'd1);
    check("flush_first_pc", bus.pc_o, 32'h104);
    for (int i = 0; i < 20; i++) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rv32i_fetch.md
# rv32i_fetch

Instruction fetch stage of the rv32i pipeline, directly upstream of decode. It keeps the fetch PC and issues single-word reads on the instruction memory bus, with at most one request outstanding. Returned words are buffered in a small FIFO. Each instruction is presented to decode as a one-cycle `data_ready_o` strobe, together with the instruction word and the PC of the *following* instruction (fetch address + 4); decode relies on that convention for AUIPC/JAL/branch arithmetic. A redirect from later stages flushes everything in flight.

## Interface
- `XLEN`, 32, data/address width.
- `FIFO_DEPTH`, 2, instruction buffer entries; power of two, ≥ 2.
- `RESET_VECTOR`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

- `clk_i`  in  1  single clock; all logic on posedge.
- `rst_i`  in  1  synchronous, active-high reset.
- `mem_addr_o`  out  XLEN  word-aligned fetch address; stable while `mem_req_o` is high.
- `mem_req_o`  out  1  read request; held high until the cycle `mem_ack_i` is sampled high.
- `mem_ack_i`  in  1  read complete; `mem_data_i` valid in this cycle; only meaningful while `mem_req_o` is high.
- `mem_data_i`  in  32  instruction word.
- `stall_i`  in  1  decode cannot accept an instruction this cycle.
- `redirect_i`  in  1  flush the pipeline and fetch from `redirect_addr_i`.
- `redirect_addr_i`  in  XLEN  new fetch address; bits [1:0] are ignored (forced to 0).
- `instruction_o`  out  32  instruction to decode.
- `pc_o`  out  XLEN  fetch address of `instruction_o` + 4.
- `data_ready_o`  out  1  one-cycle strobe: `instruction_o`/`pc_o` are new and valid.

## Operation
- Reset values:
  - fetch_pc = `RESET_VECTOR`; FIFO empty; FSM = IDLE.
  - `mem_req_o`=0, `mem_addr_o`=`RESET_VECTOR`.
  - `data_ready_o`=0, `instruction_o`=32'h0000_0013 (NOP), `pc_o`=0.
- FSM states: IDLE, REQ, DISCARD.
- IDLE → REQ when occupancy < `FIFO_DEPTH`; this drives `mem_req_o`=1 and `mem_addr_o`=fetch_pc.
- REQ, `mem_ack_i`=1:
  - push {`mem_data_i`, fetch_pc+4}; fetch_pc += 4.
  - If occupancy after this edge's push/pop is still < `FIFO_DEPTH`, stay in REQ with the new address (back-to-back); otherwise → IDLE.
- Issue rule: a request is issued only when occupancy < `FIFO_DEPTH`. Counting the in-flight request, a push therefore never overflows.
- DISCARD: `mem_req_o` stays high with the stale address until ack. The returned data is dropped. Then → IDLE, or → REQ at the redirected fetch_pc if there is space.
- Pop: when FIFO is non-empty, `stall_i`=0 and `redirect_i`=0:
  - register the head into `instruction_o`/`pc_o`;
  - `data_ready_o`=1 for the next cycle only.
  - Otherwise `data_ready_o`=0 and `instruction_o`/`pc_o` hold their values.
- Redirect (highest priority; overrides pop, push and issue):
  - flush FIFO; fetch_pc ← {`redirect_addr_i`[XLEN-1:2], 2'b00}; `data_ready_o` ← 0.
  - In REQ with no ack this cycle → DISCARD.
  - In REQ with ack this cycle → data dropped, → IDLE.
  - Otherwise → IDLE.
- `rst_i` mid-request abandons the outstanding read. After reset, any late `mem_ack_i` arriving while `mem_req_o`=0 is ignored; the memory is required to drop the request when req falls.
- Address arithmetic wraps modulo 2^XLEN (0xFFFF_FFFC + 4 = 0).
- Simultaneous push and pop on the same edge is legal; occupancy is unchanged.

## Timing
- `mem_req_o` rises on the first clock edge with `rst_i` low (cycle 1).
- Zero-wait memory (ack in the same cycle as req) gives one fetch per cycle.
- Push at edge E: the entry can pop at edge E+1, so `data_ready_o` is high in the cycle after E+1. That is 1 cycle from ack-edge to strobe when the FIFO is empty and there is no stall.
- Redirect at edge R:
  - new address on `mem_addr_o` at R (from IDLE);
  - or after the stale ack (from DISCARD).
- No `data_ready_o` for pre-redirect instructions after R.
- Sustained throughput is 1 instruction/cycle with zero-wait memory and no stalls.

## Test plan
- Reset: hold `rst_i` 3 cycles. Required: `mem_req_o`=0, `data_ready_o`=0, `instruction_o`=0x13, `pc_o`=0. Release: `mem_req_o`=1 with `mem_addr_o`=0 next cycle.
- Zero-wait stream: `mem_ack_i`=`mem_req_o`, data = address. Required: `data_ready_o` high every cycle from cycle 3, `pc_o` = 4, 8, 12, …, `instruction_o` = 0, 4, 8, ….
- Stall fill: `stall_i`=1 for 10 cycles with zero-wait memory. Required: exactly 2 acks, then `mem_req_o`=0. Release stall: 2 strobes, `pc_o` 4 then 8, then fetching resumes at 0x8.
- Redirect during a 3-wait-state request: `redirect_i` with `redirect_addr_i`=0x200 one cycle after req. Required:
  - stale address held until ack and its data never strobed;
  - next request at 0x200;
  - first strobe carries `pc_o`=0x204.
- Redirect on the ack cycle, with `redirect_addr_i`=0x103. Required: acked word dropped, FIFO flushed, next `mem_addr_o`=0x100.
- Wrap: `RESET_VECTOR`=0xFFFF_FFFC. Required: first strobe `pc_o`=0x0, second fetch address 0x0.
